simple_3: RTL and testbench

Registered 3-input Boolean function block with input-coverage tracking. It evaluates a parameterised 8-entry truth table over inputs (a, b, c) and registers the result on the clock. It also keeps a sticky record of which of the 8 input combinations have been applied since reset. It is a leaf cell of the simple-circuit group and is driven directly by a testbench or by upstream glue logic.

---
 rtl/simple_pkg.sv | 8 +
 rtl/simple_3_if.sv | 14 +
 rtl/simple_3_cov.sv | 32 +++
 rtl/simple_3.sv | 31 +++
 tb/tb_simple_3.sv | 138 +++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// Shared constants and types for the simple-circuit group.
package simple_pkg;
    localparam int IDX_W      = 3;
    localparam int N_MINTERMS = 8;
    localparam logic [N_MINTERMS-1:0] MAJORITY_TT = 8'b1110_1000;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/simple_3_if.sv
// Function inputs and observed outputs of simple_3.
interface simple_3_if;
    import simple_pkg::*;

    logic                  a;
    logic                  b;
    logic                  c;
    logic                  z;
    logic [N_MINTERMS-1:0] seen;
    logic                  all_seen;

    modport master (output a, b, c, input z, seen, all_seen);
    modport slave  (input a, b, c, output z, seen, all_seen);
endinterface

// File: rtl/simple_3_cov.sv
// Sticky record of every index sampled since reset, plus a full-coverage flag.
module simple_3_cov
    import simple_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  idx_t                  idx_i,
    output logic [N_MINTERMS-1:0] seen_o,
    output logic                  all_seen_o
);
    logic [N_MINTERMS-1:0] seen_q, seen_d;
    logic                  all_seen_q, all_seen_d;

    always_comb begin
        seen_d     = seen_q | (N_MINTERMS'(1) << idx_i);
        // Rises on the same edge that fills the last missing bit.
        all_seen_d = &seen_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q     <= '0;
            all_seen_q <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            all_seen_q <= all_seen_d;
        end
    end

    assign seen_o     = seen_q;
    assign all_seen_o = all_seen_q;
endmodule

// File: rtl/simple_3.sv
// Registered 3-input truth-table function with input-coverage tracking.
module simple_3
    import simple_pkg::*;
#(
    parameter logic [N_MINTERMS-1:0] TRUTH = MAJORITY_TT
) (
    input  logic       clk,
    input  logic       rst,
    simple_3_if.slave  bus
);
    idx_t idx;
    logic z_q, z_d;

    assign idx = {bus.a, bus.b, bus.c};
    assign z_d = TRUTH[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) z_q <= 1'b0;
        else     z_q <= z_d;
    end

    assign bus.z = z_q;

    simple_3_cov u_cov (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (idx),
        .seen_o     (bus.seen),
        .all_seen_o (bus.all_seen)
    );
endmodule

// File: tb/tb_simple_3.sv
// Directed bench: majority (default) and XOR instances driven with identical inputs.
module tb_simple_3;
    import simple_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] idx_tb;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simple_3_if bus_maj ();
    simple_3_if bus_xor ();

    assign {bus_maj.a, bus_maj.b, bus_maj.c} = idx_tb;
    assign {bus_xor.a, bus_xor.b, bus_xor.c} = idx_tb;

    simple_3 u_maj (.clk(clk), .rst(rst), .bus(bus_maj));
    simple_3 #(.TRUTH(8'b1001_0110)) u_xor (.clk(clk), .rst(rst), .bus(bus_xor));

    typedef struct {
        logic [2:0] idx;
        logic       z_maj;
        logic       z_xor;
        logic [7:0] seen;
        logic       all_seen;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic zm, input logic zx,
                           input logic [7:0] s, input logic as);
        chk({tag, ".z_maj"},    {7'd0, bus_maj.z},        {7'd0, zm});
        chk({tag, ".z_xor"},    {7'd0, bus_xor.z},        {7'd0, zx});
        chk({tag, ".seen"},     bus_maj.seen,             s);
        chk({tag, ".seen_xor"}, bus_xor.seen,             s);
        chk({tag, ".all_seen"}, {7'd0, bus_maj.all_seen}, {7'd0, as});
    endtask

    initial begin
        vecs[0] = '{3'd0, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{3'd1, 1'b0, 1'b1, 8'h03, 1'b0};
        vecs[2] = '{3'd2, 1'b0, 1'b1, 8'h07, 1'b0};
        vecs[3] = '{3'd3, 1'b1, 1'b0, 8'h0F, 1'b0};
        vecs[4] = '{3'd4, 1'b0, 1'b1, 8'h1F, 1'b0};
        vecs[5] = '{3'd5, 1'b1, 1'b0, 8'h3F, 1'b0};
        vecs[6] = '{3'd6, 1'b1, 1'b0, 8'h7F, 1'b0};
        vecs[7] = '{3'd7, 1'b1, 1'b1, 8'hFF, 1'b1};

        // Reset with inputs at 111, checked before any clock edge.
        rst    = 1'b1;
        idx_tb = 3'd7;
        #2;
        chk_all("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_all("reset_edge", 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Exhaustive sweep, each index held for two edges.
        for (int i = 0; i < 8; i++) begin
            idx_tb = vecs[i].idx;
            tick();
            chk_all($sformatf("sweep%0d", i), vecs[i].z_maj, vecs[i].z_xor,
                    vecs[i].seen, vecs[i].all_seen);
            tick();
            chk_all($sformatf("hold%0d", i), vecs[i].z_maj, vecs[i].z_xor,
                    vecs[i].seen, vecs[i].all_seen);
        end

        // Latency: input change just after an edge only shows after the next one.
        idx_tb = 3'd0;
        tick();
        chk("lat.z0", {7'd0, bus_maj.z}, 8'd0);
        idx_tb = 3'd7;
        #3;
        chk("lat.before_edge", {7'd0, bus_maj.z}, 8'd0);
        chk("lat.before_edge_xor", {7'd0, bus_xor.z}, 8'd0);
        tick();
        chk("lat.after_edge", {7'd0, bus_maj.z}, 8'd1);
        chk("lat.after_edge_xor", {7'd0, bus_xor.z}, 8'd1);

        // Sticky coverage from a fresh reset.
        rst = 1'b1;
        #2;
        chk_all("rst2", 1'b0, 1'b0, 8'h00, 1'b0);
        rst    = 1'b0;
        idx_tb = 3'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("sticky5_%0d", i), 1'b1, 1'b0, 8'h20, 1'b0);
        end
        idx_tb = 3'd2;
        tick();
        chk_all("sticky2", 1'b0, 1'b1, 8'h24, 1'b0);

        // Fill coverage, then a short asynchronous reset pulse between edges.
        for (int i = 0; i < 8; i++) begin
            idx_tb = 3'(i);
            tick();
        end
        chk_all("full", 1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        chk("full_stays", {7'd0, bus_maj.all_seen}, 8'd1);
        rst = 1'b1;
        #1;
        chk_all("midrst", 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        rst    = 1'b0;
        idx_tb = 3'd3;
        #1;
        chk_all("midrst_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_all("after_midrst", 1'b1, 1'b0, 8'h08, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
